// File: rtl/boot_mem.sv
// Boot memory: CLEAR (optional) -> LOAD from a byte stream -> RUN as CPU-visible word RAM.
// Define BOOT_MEM_CLEAR_EN to zero the array after every reset before loading.
module boot_mem #(
    parameter int ADDR_W = 10
) (
    input  logic        i_clk1,
    input  logic        i_reset,        // active-low, synchronous
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_data_in,
    output logic [15:0] o_data_out,
    input  logic        i_v,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_data,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    output logic        o_cpu_reset,
    output logic        o_fault,
    output logic [7:0]  o_ovf_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef BOOT_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_CLEAR = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
    localparam state_t RESET_STATE = S_LOAD;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [7:0]          r_hi_byte;
    logic                r_hi_valid;
    logic [15:0]         r_data_out;
    logic                r_cpu_reset;
    logic                r_fault;
    logic [7:0]          r_ovf_cnt;
    logic [15:0]         r_mem [DEPTH];

    logic                w_addr_ok;
    logic                w_accept;
    logic                w_ld_write;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [15:0]         w_wdata;

    assign w_addr_ok  = ({16'h0000, i_addr} < 32'(DEPTH));
    assign w_accept   = i_ld_valid && o_ld_ready;
    // A word completes on the low byte, or early on a high byte flagged last.
    assign w_ld_write = w_accept && (r_hi_valid || i_ld_last);

    always_ff @(posedge i_clk1) begin
        if (!i_reset) r_state <= RESET_STATE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
`ifdef BOOT_MEM_CLEAR_EN
            S_CLEAR: if (&r_ptr) w_next_state = S_LOAD;
`endif
            S_LOAD:  if (w_ld_write && (i_ld_last || &r_ptr)) w_next_state = S_RUN;
            S_RUN:   w_next_state = S_RUN;
            default: w_next_state = RESET_STATE;
        endcase
    end

    always_comb begin
        o_ld_ready = (r_state == S_LOAD);
        w_we       = 1'b0;
        w_waddr    = r_ptr;
        w_wdata    = 16'h0000;
        case (r_state)
`ifdef BOOT_MEM_CLEAR_EN
            S_CLEAR: w_we = 1'b1;
`endif
            S_LOAD: begin
                w_we    = w_ld_write;
                w_wdata = r_hi_valid ? {r_hi_byte, i_ld_data} : {i_ld_data, 8'h00};
            end
            S_RUN: begin
                w_we    = i_wr && w_addr_ok;
                w_waddr = i_addr[ADDR_W-1:0];
                w_wdata = i_data_in;
            end
            default: ;
        endcase
        if (!i_reset) w_we = 1'b0;
    end

    always_ff @(posedge i_clk1) begin
        if (!i_reset) begin
            r_ptr       <= '0;
            r_hi_byte   <= 8'h00;
            r_hi_valid  <= 1'b0;
            r_data_out  <= 16'h0000;
            r_cpu_reset <= 1'b1;
            r_fault     <= 1'b0;
            r_ovf_cnt   <= 8'h00;
        end else begin
            r_cpu_reset <= (w_next_state != S_RUN);
            case (r_state)
`ifdef BOOT_MEM_CLEAR_EN
                S_CLEAR: r_ptr <= r_ptr + ADDR_W'(1);
`endif
                S_LOAD: begin
                    if (w_ld_write) begin
                        r_hi_valid <= 1'b0;
                        r_ptr      <= r_ptr + ADDR_W'(1);
                    end else if (w_accept) begin
                        r_hi_byte  <= i_ld_data;
                        r_hi_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Read samples the array before this edge's write lands.
                    if (i_rd) r_data_out <= w_addr_ok ? r_mem[i_addr[ADDR_W-1:0]] : 16'h0000;
                    if ((i_rd || i_wr) && !w_addr_ok) r_fault <= 1'b1;
                    if (i_v && (r_ovf_cnt != 8'hFF)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset; contents change only through the write port.
    always_ff @(posedge i_clk1) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign o_data_out  = r_data_out;
    assign o_cpu_reset = r_cpu_reset;
    assign o_fault     = r_fault;
    assign o_ovf_cnt   = r_ovf_cnt;

endmodule
